// File: rtl/rggen_trigger_pending_arbiter.sv
// Counts trigger pulses per lane and serialises the pending lanes onto one
// valid/ready request channel using round-robin arbitration.
module rggen_trigger_pending_arbiter #(
  parameter int WIDTH = 1,
  parameter int COUNT_WIDTH = 4,
  localparam int LANE_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic [WIDTH-1:0]             i_trigger,
  output logic                         o_valid,
  output logic [LANE_WIDTH-1:0]        o_lane,
  input  logic                         i_ready,
  output logic [WIDTH*COUNT_WIDTH-1:0] o_pending_count,
  output logic [WIDTH-1:0]             o_overflow
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [LANE_WIDTH-1:0]  LAST_LANE = LANE_WIDTH'(WIDTH - 1);

  logic [WIDTH-1:0][COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]                  ovf_q, ovf_d;
  logic [WIDTH-1:0]                  nonzero;
  logic [LANE_WIDTH-1:0]             ptr_q, ptr_d;
  logic                              lock_q, lock_d;
  logic [LANE_WIDTH-1:0]             lock_lane_q, lock_lane_d;
  logic                              cand_found;
  logic [LANE_WIDTH-1:0]             cand_lane;
  logic [LANE_WIDTH-1:0]             idx;
  logic                              handshake;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      nonzero[i] = (cnt_q[i] != '0);
    end
  end

  // First non-empty lane at or after ptr_q, wrapping at WIDTH-1.
  always_comb begin
    cand_found = 1'b0;
    cand_lane  = '0;
    idx        = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = LANE_WIDTH'((int'(ptr_q) + k) % WIDTH);
      if (!cand_found && nonzero[idx]) begin
        cand_found = 1'b1;
        cand_lane  = idx;
      end
    end
  end

  // Request channel: a transfer happens in any cycle with o_valid && i_ready.
  // Once raised, o_valid and o_lane hold until that transfer (or clear/reset);
  // o_valid never depends on i_ready.
  assign o_valid   = lock_q || cand_found;
  assign o_lane    = lock_q ? lock_lane_q : cand_lane;
  assign handshake = o_valid && i_ready;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (i_trigger[i] && !(handshake && (o_lane == LANE_WIDTH'(i)))) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (!i_trigger[i] && handshake && (o_lane == LANE_WIDTH'(i))) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_lane_d = lock_lane_q;
    if (i_clear) begin
      ptr_d       = '0;
      lock_d      = 1'b0;
      lock_lane_d = '0;
    end else if (handshake) begin
      lock_d = 1'b0;
      ptr_d  = (o_lane == LAST_LANE) ? '0 : o_lane + LANE_WIDTH'(1);
    end else if (o_valid) begin
      lock_d      = 1'b1;
      lock_lane_d = o_lane;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_lane_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_lane_q <= lock_lane_d;
    end
  end

  assign o_pending_count = cnt_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_rggen_trigger_pending_arbiter.sv
// Directed bench for the trigger pending arbiter: a 4-lane/4-bit instance for
// latency, arbitration and locking, a 4-lane/2-bit instance for saturation.
module tb_rggen_trigger_pending_arbiter;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [3:0]  trig;
  logic        ready;
  logic        valid;
  logic [1:0]  lane;
  logic [15:0] pend;
  logic [3:0]  ovf;

  logic        s_clear;
  logic [3:0]  s_trig;
  logic        s_ready;
  logic        s_valid;
  logic [1:0]  s_lane;
  logic [7:0]  s_pend;
  logic [3:0]  s_ovf;

  int vectors = 0;
  int errors  = 0;

  rggen_trigger_pending_arbiter #(.WIDTH(4), .COUNT_WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_trigger(trig),
    .o_valid(valid), .o_lane(lane), .i_ready(ready),
    .o_pending_count(pend), .o_overflow(ovf)
  );

  rggen_trigger_pending_arbiter #(.WIDTH(4), .COUNT_WIDTH(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(s_clear), .i_trigger(s_trig),
    .o_valid(s_valid), .o_lane(s_lane), .i_ready(s_ready),
    .o_pending_count(s_pend), .o_overflow(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] cnt(input int l);
    return pend[l*4 +: 4];
  endfunction

  initial begin
    rst_n = 1'b0; clear = 1'b0; trig = '0; ready = 1'b0;
    s_clear = 1'b0; s_trig = '0; s_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_lane",  32'(lane),  32'd0);
    chk("rst_pend",  32'(pend),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single pulse, ready held high
    trig = 4'b0100; ready = 1'b1;
    tick();
    trig = '0;
    chk("t1_valid", 32'(valid),  32'd1);
    chk("t1_lane",  32'(lane),   32'd2);
    chk("t1_cnt2",  32'(cnt(2)), 32'd1);
    tick();
    chk("t1_cnt2_done",  32'(cnt(2)), 32'd0);
    chk("t1_valid_done", 32'(valid),  32'd0);

    // 2: five pulses on lane 0, then drain
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      trig = 4'b0001;
      tick();
    end
    trig = '0;
    chk("t2_cnt0", 32'(cnt(0)), 32'd5);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_grant_valid", 32'(valid), 32'd1);
      chk("t2_grant_lane",  32'(lane),  32'd0);
      tick();
    end
    chk("t2_valid_done", 32'(valid),  32'd0);
    chk("t2_cnt0_done",  32'(cnt(0)), 32'd0);

    // 3: round-robin order, pointer starting at 0 after clear
    ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0; trig = 4'b1011;
    tick();
    trig = '0; ready = 1'b1;
    chk("t3_lane_a", 32'(lane), 32'd0);
    tick();
    chk("t3_lane_b", 32'(lane), 32'd1);
    tick();
    chk("t3_lane_c", 32'(lane), 32'd3);
    tick();
    chk("t3_valid_idle", 32'(valid), 32'd0);
    ready = 1'b0; trig = 4'b1001;
    tick();
    trig = '0; ready = 1'b1;
    chk("t3_wrap_a", 32'(lane), 32'd0);
    tick();
    chk("t3_wrap_b", 32'(lane), 32'd3);
    tick();
    chk("t3_wrap_idle", 32'(valid), 32'd0);

    // 4: a locked request ignores a newly pending lower lane
    ready = 1'b0; trig = 4'b0010;
    tick();
    trig = '0;
    chk("t4_lane_req", 32'(lane), 32'd1);
    tick();
    trig = 4'b0001;
    tick();
    trig = '0;
    chk("t4_cnt0",      32'(cnt(0)), 32'd1);
    chk("t4_lane_hold", 32'(lane),   32'd1);
    tick();
    chk("t4_lane_hold2", 32'(lane),  32'd1);
    chk("t4_valid_hold", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    chk("t4_lane_next", 32'(lane), 32'd0);
    tick();
    chk("t4_valid_idle", 32'(valid), 32'd0);

    // 5: saturation on the 2-bit instance, then clear
    for (int i = 0; i < 4; i++) begin
      s_trig = 4'b1000;
      tick();
    end
    s_trig = '0;
    chk("t5_cnt3",  32'(s_pend[7:6]), 32'd3);
    chk("t5_ovf",   32'(s_ovf),       32'h8);
    chk("t5_valid", 32'(s_valid),     32'd1);
    chk("t5_lane",  32'(s_lane),      32'd3);
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    chk("t5_clr_pend",  32'(s_pend),  32'd0);
    chk("t5_clr_ovf",   32'(s_ovf),   32'd0);
    chk("t5_clr_valid", 32'(s_valid), 32'd0);

    // 6: trigger and grant on the same lane in one cycle
    ready = 1'b0; trig = 4'b0100;
    tick();
    tick();
    chk("t6_cnt2_pre", 32'(cnt(2)), 32'd2);
    ready = 1'b1;
    tick();
    trig = '0;
    chk("t6_cnt2_same", 32'(cnt(2)), 32'd2);
    tick();
    chk("t6_cnt2_dec", 32'(cnt(2)), 32'd1);
    tick();
    chk("t6_cnt2_zero", 32'(cnt(2)), 32'd0);

    // 6b: asynchronous reset while a request is outstanding
    ready = 1'b0; trig = 4'b0001;
    tick();
    trig = '0;
    chk("t6_req_valid", 32'(valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", 32'(valid), 32'd0);
    chk("t6_arst_lane",  32'(lane),  32'd0);
    chk("t6_arst_pend",  32'(pend),  32'd0);
    chk("t6_arst_ovf",   32'(ovf),   32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("t6_post_valid", 32'(valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
